// File: rtl/logic_gate_checker.sv
// On-chip self-test sequencer for the two-input gate block:
// sweeps {a,b}, waits a settle time, and checks all eight gate outputs.
module logic_gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  output logic       a_out,
  output logic       b_out,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       xor_in,
  input  logic       anot_in,
  input  logic       bnot_in,
  input  logic       nand_in,
  input  logic       nor_in,
  input  logic       xnor_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [7:0] err_cnt_out,
  output logic       fail_valid_out,
  output logic [1:0] fail_vec_out,
  output logic [7:0] fail_mask_out
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] settle_q, settle_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       fail_valid_q, fail_valid_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic [7:0] fail_mask_q, fail_mask_d;

  logic       va, vb;
  logic [7:0] expected;
  logic [7:0] observed;
  logic [7:0] mismatch;
  logic [7:0] err_inc;

  always_comb begin
    va       = vec_q[1];
    vb       = vec_q[0];
    expected = {~(va ^ vb), ~(va | vb), ~(va & vb), ~vb, ~va,
                va ^ vb, va | vb, va & vb};
    observed = {xnor_in, nor_in, nand_in, bnot_in, anot_in,
                xor_in, or_in, and_in};
    mismatch = observed ^ expected;
    // Error counter saturates rather than wrapping
    err_inc  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_d     = settle_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_mask_d  = fail_mask_q;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          err_cnt_d    = 8'd0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'd0;
          fail_mask_d  = 8'd0;
          pass_d       = 1'b0;
          vec_d        = 2'd0;
          pass_cnt_d   = 8'd0;
          settle_d     = 4'd0;
          busy_d       = 1'b1;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (|mismatch) begin
          err_cnt_d = err_inc;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
            fail_mask_d  = mismatch;
          end
        end
        if (vec_q == 2'd3 && pass_cnt_q == PASS_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 8'd0);
          state_d = DONE;
        end else begin
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'd3) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
          end
          settle_d = 4'd0;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      vec_q        <= 2'd0;
      pass_cnt_q   <= 8'd0;
      settle_q     <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= 8'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
      fail_mask_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_q     <= settle_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  assign a_out          = vec_q[1];
  assign b_out          = vec_q[0];
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign pass_out       = pass_q;
  assign err_cnt_out    = err_cnt_q;
  assign fail_valid_out = fail_valid_q;
  assign fail_vec_out   = fail_vec_q;
  assign fail_mask_out  = fail_mask_q;

endmodule

// File: tb/tb_logic_gate_checker.sv
// Scoreboard bench: three checker instances, each with a faultable
// gate model; expected run results come from a sweep-level model.
module tb_logic_gate_checker;

  localparam int NDUT = 3;
  localparam int SP [NDUT] = '{2, 1, 2};
  localparam int PP [NDUT] = '{1, 70, 2};

  typedef struct {
    int         len;
    logic       pass;
    logic [7:0] err;
    logic       fv;
    logic [1:0] vec;
    logic [7:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NDUT-1:0] start;
  logic [NDUT-1:0] a_o, b_o, busy, done, pass, fv;
  logic [7:0] err   [NDUT];
  logic [1:0] fvec  [NDUT];
  logic [7:0] fmask [NDUT];
  logic [7:0] gin   [NDUT];
  logic [7:0] inv   [NDUT];
  logic [7:0] s0    [NDUT];

  exp_t exq [NDUT][$];
  int   ndone [NDUT];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Ideal gate outputs from the sum of the two input bits
  function automatic logic [7:0] truth(logic a, logic b);
    int s;
    logic [7:0] r;
    s    = int'(a) + int'(b);
    r[0] = (s == 2);
    r[1] = (s >= 1);
    r[2] = (s == 1);
    r[3] = (a == 1'b0);
    r[4] = (b == 1'b0);
    r[5] = (s != 2);
    r[6] = (s == 0);
    r[7] = (s != 1);
    return r;
  endfunction

  function automatic exp_t model(int d, logic [7:0] iv, logic [7:0] sz);
    exp_t e;
    int cnt;
    logic [7:0] t, m;
    e.fv = 1'b0; e.vec = 2'd0; e.mask = 8'd0;
    cnt = 0;
    for (int p = 0; p < PP[d]; p++) begin
      for (int v = 0; v < 4; v++) begin
        t = truth(v[1], v[0]);
        m = t ^ ((t ^ iv) & ~sz);
        if (m != 8'd0) begin
          cnt++;
          if (!e.fv) begin
            e.fv = 1'b1; e.vec = v[1:0]; e.mask = m;
          end
        end
      end
    end
    e.err  = (cnt > 255) ? 8'd255 : 8'(cnt);
    e.pass = (cnt == 0);
    e.len  = 4 * PP[d] * (SP[d] + 1);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    assign gin[i] = (truth(a_o[i], b_o[i]) ^ inv[i]) & ~s0[i];

    logic_gate_checker #(
      .SETTLE_CYCLES(SP[i]),
      .PASSES       (PP[i])
    ) u_dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .start_in      (start[i]),
      .a_out         (a_o[i]),
      .b_out         (b_o[i]),
      .and_in        (gin[i][0]),
      .or_in         (gin[i][1]),
      .xor_in        (gin[i][2]),
      .anot_in       (gin[i][3]),
      .bnot_in       (gin[i][4]),
      .nand_in       (gin[i][5]),
      .nor_in        (gin[i][6]),
      .xnor_in       (gin[i][7]),
      .busy_out      (busy[i]),
      .done_out      (done[i]),
      .pass_out      (pass[i]),
      .err_cnt_out   (err[i]),
      .fail_valid_out(fv[i]),
      .fail_vec_out  (fvec[i]),
      .fail_mask_out (fmask[i])
    );

    initial begin : mon
      int blen;
      exp_t e;
      blen = 0;
      ndone[i] = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          blen = 0;
        end else begin
          if (busy[i]) blen++;
          if (done[i]) begin
            ndone[i]++;
            chk($sformatf("d%0d done_expected", i),
                32'(exq[i].size() != 0), 32'd1);
            if (exq[i].size() != 0) begin
              e = exq[i].pop_front();
              chk($sformatf("d%0d busy_len", i), 32'(blen), 32'(e.len));
              chk($sformatf("d%0d busy_at_done", i), 32'(busy[i]), 32'd0);
              chk($sformatf("d%0d pass", i), 32'(pass[i]), 32'(e.pass));
              chk($sformatf("d%0d err_cnt", i), 32'(err[i]), 32'(e.err));
              chk($sformatf("d%0d fail_valid", i), 32'(fv[i]), 32'(e.fv));
              chk($sformatf("d%0d fail_vec", i), 32'(fvec[i]), 32'(e.vec));
              chk($sformatf("d%0d fail_mask", i), 32'(fmask[i]), 32'(e.mask));
            end
            blen = 0;
          end
        end
      end
    end
  end

  task automatic check_zero(int d, string tag);
    chk($sformatf("%s d%0d a", tag, d), 32'(a_o[d]), 32'd0);
    chk($sformatf("%s d%0d b", tag, d), 32'(b_o[d]), 32'd0);
    chk($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
    chk($sformatf("%s d%0d done", tag, d), 32'(done[d]), 32'd0);
    chk($sformatf("%s d%0d pass", tag, d), 32'(pass[d]), 32'd0);
    chk($sformatf("%s d%0d err", tag, d), 32'(err[d]), 32'd0);
    chk($sformatf("%s d%0d fv", tag, d), 32'(fv[d]), 32'd0);
    chk($sformatf("%s d%0d fvec", tag, d), 32'(fvec[d]), 32'd0);
    chk($sformatf("%s d%0d fmask", tag, d), 32'(fmask[d]), 32'd0);
  endtask

  task automatic wait_done(int d);
    logic found;
    int lim;
    found = 1'b0;
    lim = 4 * PP[d] * (SP[d] + 1) + 20;
    for (int k = 0; k < lim && !found; k++) begin
      @(negedge clk);
      if (done[d]) found = 1'b1;
    end
    chk($sformatf("d%0d done_timeout", d), 32'(found), 32'd1);
  endtask

  task automatic run(int d, logic [7:0] iv, logic [7:0] sz);
    @(negedge clk);
    inv[d] = iv;
    s0[d]  = sz;
    exq[d].push_back(model(d, iv, sz));
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    wait_done(d);
    @(negedge clk);
  endtask

  initial begin
    int n0, n;
    logic found;
    int d;
    logic [7:0] iv, sz;
    start = '0;
    for (int k = 0; k < NDUT; k++) begin
      inv[k] = 8'd0;
      s0[k]  = 8'd0;
    end
    #1;
    for (int k = 0; k < NDUT; k++) check_zero(k, "reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(0, 8'h00, 8'h00);
    run(0, 8'h00, 8'h01);
    run(0, 8'h00, 8'h00);
    run(2, 8'h04, 8'h00);
    run(1, 8'hFF, 8'h00);

    // Extra start pulses during a run must be ignored
    n0 = ndone[0];
    @(negedge clk);
    exq[0].push_back(model(0, 8'h00, 8'h00));
    start[0] = 1'b1;
    @(negedge clk);
    chk("accept busy", 32'(busy[0]), 32'd1);
    chk("accept vec00", 32'({a_o[0], b_o[0]}), 32'd0);
    start[0] = 1'b0;
    repeat (3) begin
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
    end
    wait_done(0);
    repeat (15) @(negedge clk);
    chk("single done", 32'(ndone[0] - n0), 32'd1);

    // Start held high: back-to-back runs with one idle cycle
    @(negedge clk);
    exq[0].push_back(model(0, 8'h00, 8'h00));
    exq[0].push_back(model(0, 8'h00, 8'h00));
    start[0] = 1'b1;
    wait_done(0);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      n++;
      if (busy[0]) found = 1'b1;
    end
    chk("held gap", 32'(n), 32'd2);
    wait_done(0);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of the third vector
    @(negedge clk);
    exq[0].push_back(model(0, 8'h00, 8'h00));
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (busy[0] && {a_o[0], b_o[0]} == 2'b10) found = 1'b1;
    end
    chk("reach vec2", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    exq[0].delete();
    #1 check_zero(0, "midrun_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = ndone[0];
    repeat (20) @(negedge clk);
    chk("no done after rst", 32'(ndone[0] - n0), 32'd0);
    run(0, 8'h00, 8'h00);

    for (int it = 0; it < 14; it++) begin
      d  = int'($urandom_range(0, NDUT - 1));
      iv = 8'($urandom & $urandom & $urandom);
      sz = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin
        iv = 8'd0;
        sz = 8'd0;
      end
      run(d, iv, sz);
    end

    for (int k = 0; k < NDUT; k++)
      chk($sformatf("d%0d queue drained", k), 32'(exq[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
